// File: rtl/sdram_frame_fetch.sv
// sdram_frame_fetch
// Read-side traffic master: fetches one frame per start as a series of
// full-page SDRAM read bursts into a first-word fall-through FIFO, which is
// drained by a valid/ready pixel stream. A burst is requested only when the
// FIFO can absorb a whole page, because the controller cannot be paused
// mid-burst.
module sdram_frame_fetch #(
    parameter int ADDR_W          = 15,
    parameter int BURST_LEN       = 512,
    parameter int PAGES_PER_FRAME = 600,
    parameter int BASE_PAGE       = 0,
    parameter int FIFO_DEPTH      = 1024
) (
    input  logic              CLK_OUT,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ready,
    output logic              rw_en,
    output logic              rw,
    output logic [ADDR_W-1:0] f_addr,
    input  logic [15:0]       s2f_data,
    input  logic              s2f_data_valid,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PAGE_W = (PAGES_PER_FRAME > 1) ? $clog2(PAGES_PER_FRAME) : 1;

    localparam logic [CNT_W-1:0]  SPACE_LIMIT = CNT_W'(FIFO_DEPTH - BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [PAGE_W-1:0] LAST_PAGE   = PAGE_W'(PAGES_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        REQ,
        BURST
    } state_t;

    state_t              state_q, state_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic [15:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                push, pop;

    // Words are only accepted while a burst we requested is in flight.
    assign push      = (state_q == BURST) && s2f_data_valid;
    assign pop       = pix_valid && pix_ready;
    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? mem[rd_ptr_q] : 16'd0;
    assign busy      = (state_q != IDLE);
    assign f_addr    = addr_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

    // Next-state logic: frame sequencing, request strobe and page/beat tracking.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        rw_en     = 1'b0;
        rw        = 1'b0;
        // The done cycle is still treated as busy, so such a start is an overrun.
        overrun_d = overrun_q | (start & (busy | done_q));
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d = WAIT_SPACE;
                    page_d  = '0;
                    addr_d  = ADDR_W'(BASE_PAGE);
                end
            end
            WAIT_SPACE: begin
                if (count_q <= SPACE_LIMIT) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                rw_en = ready;
                rw    = ready;
                if (ready) begin
                    state_d = BURST;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (s2f_data_valid) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        if (page_q == LAST_PAGE) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            page_d  = page_q + PAGE_W'(1);
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = WAIT_SPACE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge CLK_OUT or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            page_q    <= '0;
            beat_q    <= '0;
            addr_q    <= ADDR_W'(BASE_PAGE);
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge CLK_OUT or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge CLK_OUT) begin
        if (push) begin
            mem[wr_ptr_q] <= s2f_data;
        end
    end

endmodule

// File: tb/tb_sdram_frame_fetch.sv
// tb_sdram_frame_fetch
// Drives sdram_frame_fetch with a behavioural SDRAM controller (returns
// page*BURST_LEN+k for word k) and checks the pixel stream, request
// addresses, done/busy/overrun against a frame-level reference model.
module tb_sdram_frame_fetch;

    localparam int ADDR_W      = 15;
    localparam int BURST_LEN   = 512;
    localparam int PAGES       = 4;
    localparam int BASE_PAGE   = 0;
    localparam int FIFO_DEPTH  = 1024;
    localparam int FRAME_WORDS = BURST_LEN * PAGES;

    logic              CLK_OUT = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              ready = 1'b0;
    logic              rw_en, rw;
    logic [ADDR_W-1:0] f_addr;
    logic [15:0]       s2f_data = 16'd0;
    logic              s2f_data_valid = 1'b0;
    logic [15:0]       pix_data;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic              busy, done, overrun;

    sdram_frame_fetch #(
        .ADDR_W(ADDR_W),
        .BURST_LEN(BURST_LEN),
        .PAGES_PER_FRAME(PAGES),
        .BASE_PAGE(BASE_PAGE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .CLK_OUT(CLK_OUT),
        .rst_n(rst_n),
        .start(start),
        .ready(ready),
        .rw_en(rw_en),
        .rw(rw),
        .f_addr(f_addr),
        .s2f_data(s2f_data),
        .s2f_data_valid(s2f_data_valid),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    always #5 CLK_OUT = ~CLK_OUT;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model state
    int expQ[$];
    int modelCount;
    bit modelBusy;
    bit expOverrun;
    int pageInFrame;
    bit expDoneNow;

    // Controller model state
    bit burstActive;
    int burstLat;
    int burstK;
    int burstAddr;
    int burstPage;
    bit reqSeen;
    bit drovePush;
    bit popSeen;
    bit finalDriven;

    // Stimulus controls
    int readyMode;   // 0 auto, 1 forced low, 2 forced high
    int popMode;     // 0 never, 1 always, 2 random
    bit startPulse;
    bit startOnDone;
    int rwEnCount;
    int doneCount;

    typedef struct {
        int readyMode;
        bit expRwEn;
        bit expRw;
    } vec_t;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    endtask

    task automatic clearModel();
        expQ.delete();
        modelCount  = 0;
        modelBusy   = 0;
        expOverrun  = 0;
        pageInFrame = 0;
        expDoneNow  = 0;
        burstActive = 0;
        burstK      = 0;
        reqSeen     = 0;
        drovePush   = 0;
        popSeen     = 0;
        finalDriven = 0;
        startPulse  = 0;
        startOnDone = 0;
    endtask

    // One clock: account for the last edge, drive new inputs, check outputs.
    task automatic applyStimulus();
        @(posedge CLK_OUT);
        #1;
        if (drovePush) modelCount++;
        if (popSeen) modelCount--;
        expDoneNow  = finalDriven;
        drovePush   = 0;
        popSeen     = 0;
        finalDriven = 0;
        if (reqSeen) begin
            burstActive = 1;
            burstLat    = $urandom_range(1, 3);
            burstK      = 0;
            reqSeen     = 0;
        end
        if (burstActive && burstK == BURST_LEN) burstActive = 0;

        start = startPulse || (startOnDone && done);
        if (startOnDone && done) startOnDone = 0;
        startPulse = 0;
        case (readyMode)
            0:       ready = !burstActive;
            1:       ready = 1'b0;
            default: ready = 1'b1;
        endcase
        s2f_data_valid = 1'b0;
        s2f_data       = 16'hDEAD;
        if (burstActive) begin
            if (burstLat > 0) begin
                burstLat--;
            end else if ($urandom_range(0, 3) != 0) begin
                s2f_data_valid = 1'b1;
                s2f_data       = 16'(burstAddr * BURST_LEN + burstK);
                drovePush      = 1;
                if (burstK == BURST_LEN - 1 && burstPage == PAGES - 1) finalDriven = 1;
                burstK++;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            s2f_data_valid = 1'b1;
        end
        pix_ready = (popMode == 1) ? 1'b1 : (popMode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
        #1;

        checkOutput("pix_valid", pix_valid, modelCount > 0);
        if (expDoneNow) modelBusy = 0;
        checkOutput("done", done, expDoneNow);
        checkOutput("busy", busy, modelBusy);
        checkOutput("overrun", overrun, expOverrun);
        if (done) doneCount++;
        if (burstActive) checkOutput("f_addr_hold", f_addr, (BASE_PAGE + burstPage) % (2 ** ADDR_W));
        if (rw_en) begin
            rwEnCount++;
            checkOutput("rw_with_rw_en", rw, 1);
            checkOutput("rw_en_needs_ready", ready, 1);
            checkOutput("f_addr_at_req", f_addr, (BASE_PAGE + pageInFrame) % (2 ** ADDR_W));
            checkOutput("space_at_req", modelCount <= FIFO_DEPTH - BURST_LEN, 1);
            burstAddr = int'(f_addr);
            burstPage = pageInFrame;
            pageInFrame++;
            reqSeen = 1;
        end else if (rw) begin
            checkOutput("rw_without_rw_en", rw, 0);
        end
        if (pix_valid && pix_ready) begin
            popSeen = 1;
            if (expQ.size() == 0) checkOutput("pix_extra_word", pix_valid, 0);
            else checkOutput("pix_data", pix_data, expQ.pop_front());
        end
        if (start) begin
            if (modelBusy || expDoneNow) begin
                expOverrun = 1;
            end else begin
                modelBusy   = 1;
                pageInFrame = 0;
                for (int i = 0; i < FRAME_WORDS; i++) expQ.push_back(BASE_PAGE * BURST_LEN + i);
            end
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic waitFrameDone(input string name, input int budget);
        int base = doneCount;
        int c = 0;
        while (doneCount == base && c < budget) begin
            applyStimulus();
            c++;
        end
        runCycles(30);
        checkOutput(name, doneCount - base, 1);
    endtask

    task automatic drainAll(input int budget);
        int c = 0;
        popMode = 1;
        while (pix_valid && c < budget) begin
            applyStimulus();
            c++;
        end
        checkOutput("drained", pix_valid, 0);
        checkOutput("all_pixels_seen", expQ.size(), 0);
    endtask

    task automatic doReset(input int n);
        rst_n          = 1'b0;
        start          = 1'b0;
        ready          = 1'b0;
        s2f_data_valid = 1'b0;
        pix_ready      = 1'b0;
        clearModel();
        #1;
        checkOutput("reset_ctrl_outputs", {rw_en, rw, pix_valid, busy, done, overrun}, 0);
        checkOutput("reset_f_addr", f_addr, BASE_PAGE);
        checkOutput("reset_pix_data", pix_data, 0);
        repeat (n) @(posedge CLK_OUT);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        int c;
        int base;
        vecs = '{'{1, 1'b0, 1'b0}, '{2, 1'b1, 1'b1}, '{2, 1'b0, 1'b0},
                 '{1, 1'b0, 1'b0}, '{2, 1'b0, 1'b0}};
        readyMode = 0;
        popMode   = 0;
        rwEnCount = 0;
        doneCount = 0;
        clearModel();

        // Reset and idle: nothing moves without start, stray valids are ignored
        doReset(3);
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            checkOutput("idle_rw_en", rw_en, 0);
            checkOutput("idle_f_addr", f_addr, BASE_PAGE);
        end

        // Ready held low in REQ, then the vector table around the handshake
        readyMode  = 1;
        popMode    = 2;
        startPulse = 1;
        applyStimulus();
        for (int i = 0; i < 50; i++) begin
            applyStimulus();
            checkOutput("req_ready_low_rw_en", rw_en, 0);
        end
        for (int i = 0; i < 5; i++) begin
            readyMode = vecs[i].readyMode;
            applyStimulus();
            checkOutput("vec_rw_en", rw_en, vecs[i].expRwEn);
            checkOutput("vec_rw", rw, vecs[i].expRw);
        end
        readyMode = 0;
        waitFrameDone("frame1_done", 20000);
        drainAll(3000);

        // Full frame at full drain rate, with a start landing on the done cycle
        popMode     = 1;
        startPulse  = 1;
        startOnDone = 1;
        waitFrameDone("frame2_done", 20000);
        runCycles(20);
        checkOutput("start_on_done_overrun", overrun, 1);
        checkOutput("start_on_done_no_fetch", busy, 0);
        drainAll(3000);
        doReset(2);

        // Backpressure: FIFO fills with two pages, third request waits for space
        popMode    = 0;
        base       = rwEnCount;
        startPulse = 1;
        c = 0;
        while (!(rwEnCount - base == 2 && !burstActive && !reqSeen) && c < 10000) begin
            applyStimulus();
            c++;
        end
        runCycles(200);
        checkOutput("bp_requests", rwEnCount - base, 2);
        checkOutput("bp_fifo_full_valid", pix_valid, 1);
        popMode = 1;
        c = 0;
        while (rwEnCount - base < 3 && c < 2000) begin
            applyStimulus();
            c++;
        end
        checkOutput("bp_third_request", rwEnCount - base, 3);
        waitFrameDone("bp_frame_done", 20000);
        drainAll(3000);

        // Start mid-frame sets sticky overrun without disturbing the fetch
        popMode    = 2;
        startPulse = 1;
        runCycles(700);
        startPulse = 1;
        runCycles(2);
        checkOutput("overrun_set", overrun, 1);
        waitFrameDone("overrun_frame_done", 20000);
        drainAll(3000);
        checkOutput("overrun_sticky", overrun, 1);

        // Reset in the middle of page 1, then a clean fetch from the base page
        popMode    = 1;
        startPulse = 1;
        c = 0;
        while (!(burstActive && burstPage == 1 && burstK >= 200) && c < 10000) begin
            applyStimulus();
            c++;
        end
        checkOutput("reached_page1_beat200", burstK >= 200, 1);
        doReset(2);
        runCycles(5);
        checkOutput("post_reset_pix_valid", pix_valid, 0);
        checkOutput("post_reset_busy", busy, 0);
        startPulse = 1;
        waitFrameDone("refetch_done", 20000);
        drainAll(3000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
